dma_timing_ctrl: RTL and testbench
==================================

Name: dma_timing_ctrl

Overview:
Transfer-timing state machine for the 8237A-style DMA controller. It sits directly downstream of the priority stage: it takes the registered valid-request lines and the one-hot priority grant, runs the HRQ/HLDA bus handshake, and sequences each transfer through states SI/S0/S1/S2/S3/S4. It drives the bus command strobes, address-strobe and enable, the count/address step pulse, and EOP. It returns hrq and validDACK to the priority stage.

Parameters:
NUM_CH, 4, number of DMA channels. Grant, request and status vectors are NUM_CH wide.
CH_W, 2, width of the encoded active-channel index.

Ports:
CLK  in  1  system clock; all state updates on rising edge
RESET  in  1  asynchronous, active-low reset
valid_dreq  in  NUM_CH  registered valid requests from priority stage (active-high)
grant  in  NUM_CH  one-hot priority-encoder output; zero means no winner
hlda  in  1  hold acknowledge from CPU
cmd_disable  in  1  command register bit 2; 1 = controller disabled
mode_xfer  in  2*NUM_CH  per-channel transfer type [1:0]: 00 verify, 01 write, 10 read, 11 treated as verify
mode_svc  in  2*NUM_CH  per-channel service mode [1:0]: 00 demand, 01 single, 10 block, 11 treated as single
tc_in  in  1  terminal count from the count block; valid for the active channel in S3
eop_in_n  in  1  external end-of-process, active-low
upper_addr_chg  in  1  1 = next address changes A[15:8], so S1 is required
hrq  out  1  hold request (to priority stage and pin)
validDACK  out  1  DACK-valid qualifier for the active channel
active_ch  out  CH_W  channel latched for the current service
aen  out  1  address enable
adstb  out  1  upper-address strobe
memr_n, memw_n, ior_n, iow_n  out  1 each  active-low bus commands
count_step  out  1  one-cycle pulse: decrement count, step address
eop_out_n  out  1  active-low EOP output
tc_status  out  NUM_CH  sticky terminal-count status bits; clear via tc_clr
tc_clr  in  1  status-register read strobe; clears tc_status

Behaviour:
- Reset (RESET=0, async): state=SI, hrq=0, validDACK=0, aen=0, adstb=0, all *_n=1, eop_out_n=1, count_step=0, tc_status=0, active_ch=0.
- SI: if !cmd_disable and |valid_dreq, then hrq<=1 and go to S0. Otherwise stay in SI.
- S0: hrq held at 1.
  - If hlda=1 and grant!=0: latch active_ch=encode(grant) and go to S1.
  - If the grant is withdrawn before hlda (valid_dreq==0): hrq<=0 and go to SI.
  - active_ch is frozen from S1 until the return to SI.
- S1: aen=1, adstb=1 for exactly one cycle, then go to S2.
- S2: aen=1, validDACK=1.
  - Read type: memr_n=0.
  - Write type: ior_n=0.
  - Verify: no strobe.
  - Go to S3.
- S3: aen=1, validDACK=1. The read strobe stays asserted.
  - Read type: iow_n=0.
  - Write type: memw_n=0.
  - Sample tc_in and eop_in_n. Go to S4.
- S4: all commands deasserted, count_step=1 for one cycle, validDACK=1.
  - If tc sampled: eop_out_n=0 for this cycle and tc_status[active_ch]<=1.
  - Next state:
    - tc, eop_in_n sampled low, or single mode: hrq<=0, go to SI (bus released for at least one cycle).
    - block mode otherwise: go to S1 if upper_addr_chg, else S2.
    - demand mode: if valid_dreq[active_ch] is still 1, continue as block. Otherwise hrq<=0 and go to SI with no count_step suppression.
- hlda drops in S1–S4: in the next cycle go to SI, deassert all commands and validDACK, hrq<=0. No count_step is issued.
- cmd_disable rising mid-transfer: the current transfer completes through S4, then the block goes to SI.
- tc_clr and a same-cycle tc set: the set wins.
- Minimum transfer latency: 4 cycles (S1–S4), or 3 cycles in a block burst without S1.

Test Plan:
1. Channel 2 single/read, valid_dreq=0100, grant=0100, hlda asserted 2 cycles after hrq.
   - Required: S1 adstb pulse; memr_n low in S2–S3; iow_n low in S3; count_step in S4; hrq=0 in the next cycle; active_ch=2.
2. Channel 0 block/write, upper_addr_chg=0, tc_in=1 on the 3rd transfer.
   - Required: S1 only once; 3 count_step pulses spaced 3 cycles apart; eop_out_n low in the final S4; tc_status=0001.
3. Channel 1 demand/verify; valid_dreq[1] drops after 2 transfers.
   - Required: no command strobes; 2 count_step pulses; return to SI; hrq=0.
4. Block transfer, eop_in_n pulled low during S3 of the 2nd transfer.
   - Required: SI after that S4; tc_status unchanged; eop_out_n stays 1.
5. hlda deasserted during S2.
   - Required: next cycle in SI; all *_n=1; validDACK=0; no count_step. Then assert RESET=0 mid-S3: outputs reach reset values immediately, without waiting for a clock edge.
6. cmd_disable=1 with valid_dreq=1111.
   - Required: hrq stays 0. tc_clr together with a tc set in the same cycle leaves that tc_status bit at 1.

Source files
------------

// File: rtl/dma_timing_ctrl.sv
// ---------------------------------------------------------------------------
// dma_timing_ctrl
//
// Transfer-timing state machine for an 8237A-style DMA controller. It runs
// the HRQ/HLDA bus handshake with the CPU and then sequences each transfer
// through SI/S0/S1/S2/S3/S4. All outputs are registered: each one is decoded
// from the state being entered, so it changes cleanly on the clock edge.
//
// Ports
//   CLK            system clock, rising edge
//   RESET          asynchronous active-low reset
//   valid_dreq     registered valid requests from the priority stage
//   grant          one-hot priority grant; zero means no winner
//   hlda           hold acknowledge from the CPU
//   cmd_disable    1 = controller disabled (no new services are started)
//   mode_xfer      per-channel transfer type, 2 bits per channel
//                  (00 verify, 01 write, 10 read, 11 verify)
//   mode_svc       per-channel service mode, 2 bits per channel
//                  (00 demand, 01 single, 10 block, 11 single)
//   tc_in          terminal count for the active channel, sampled in S3
//   eop_in_n       external end-of-process, active-low, sampled in S3
//   upper_addr_chg 1 = the next address changes A[15:8], so S1 is needed
//   tc_clr         status-register read strobe; clears tc_status
//   hrq            hold request
//   validDACK      DACK-valid qualifier for the active channel (S2..S4)
//   active_ch      channel latched for the current service
//   aen, adstb     address enable / upper-address strobe
//   memr_n, memw_n, ior_n, iow_n  active-low bus commands
//   count_step     one-cycle pulse in S4: decrement count, step address
//   eop_out_n      active-low EOP, driven in the S4 that reaches terminal count
//   tc_status      sticky per-channel terminal-count bits
// ---------------------------------------------------------------------------
module dma_timing_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_CH-1:0]     valid_dreq,
  input  logic [NUM_CH-1:0]     grant,
  input  logic                  hlda,
  input  logic                  cmd_disable,
  input  logic [2*NUM_CH-1:0]   mode_xfer,
  input  logic [2*NUM_CH-1:0]   mode_svc,
  input  logic                  tc_in,
  input  logic                  eop_in_n,
  input  logic                  upper_addr_chg,
  input  logic                  tc_clr,
  output logic                  hrq,
  output logic                  validDACK,
  output logic [CH_W-1:0]       active_ch,
  output logic                  aen,
  output logic                  adstb,
  output logic                  memr_n,
  output logic                  memw_n,
  output logic                  ior_n,
  output logic                  iow_n,
  output logic                  count_step,
  output logic                  eop_out_n,
  output logic [NUM_CH-1:0]     tc_status
);

  typedef enum logic [2:0] {
    ST_SI,   // idle, bus not requested
    ST_S0,   // hrq raised, waiting for hlda
    ST_S1,   // upper address strobe
    ST_S2,   // read-side command
    ST_S3,   // write-side command, sample tc / eop
    ST_S4    // commands off, step count/address
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              tc_seen;     // tc_in sampled in the last S3
  logic              eop_seen;    // eop_in_n low sampled in the last S3
  logic [1:0]        xfer;
  logic [1:0]        svc;
  logic              is_read;
  logic              is_write;
  logic              end_service;
  logic              tc_set;
  logic [NUM_CH-1:0] tc_set_mask;

  // Lowest set bit of the grant vector; the grant is one-hot in practice.
  function automatic logic [CH_W-1:0] encode(input logic [NUM_CH-1:0] g);
    encode = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (g[i]) encode = CH_W'(i);
    end
  endfunction

  // Mode fields of the latched channel. active_ch is already stable when
  // S2 is entered, so the command decode below always sees the right type.
  assign xfer     = mode_xfer[{active_ch, 1'b0} +: 2];
  assign svc      = mode_svc[{active_ch, 1'b0} +: 2];
  assign is_read  = (xfer == 2'b10);
  assign is_write = (xfer == 2'b01);

  // Terminal count lands on the S3 -> S4 edge. Only reached when hlda is
  // still held, otherwise the service is abandoned without a step.
  assign tc_set = (state == ST_S3) && hlda && tc_in;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    tc_set_mask            = '0;
    tc_set_mask[active_ch] = tc_set;

    // Service ends after S4 on tc, external EOP, a disable request, single
    // mode (svc[0] covers 01 and 11), or a demand request that went away.
    end_service = tc_seen || eop_seen || cmd_disable || svc[0] ||
                  ((svc == 2'b00) && !valid_dreq[active_ch]);

    state_nxt = state;
    unique case (state)
      ST_SI: if (!cmd_disable && (|valid_dreq)) state_nxt = ST_S0;
      ST_S0: begin
        if (hlda && (|grant))     state_nxt = ST_S1;
        else if (!(|valid_dreq))  state_nxt = ST_SI;
      end
      ST_S1: state_nxt = hlda ? ST_S2 : ST_SI;
      ST_S2: state_nxt = hlda ? ST_S3 : ST_SI;
      ST_S3: state_nxt = hlda ? ST_S4 : ST_SI;
      ST_S4: begin
        if (!hlda || end_service) state_nxt = ST_SI;
        else if (upper_addr_chg)  state_nxt = ST_S1;
        else                      state_nxt = ST_S2;
      end
      default: state_nxt = ST_SI;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_SI;
      hrq        <= 1'b0;
      validDACK  <= 1'b0;
      active_ch  <= '0;
      aen        <= 1'b0;
      adstb      <= 1'b0;
      memr_n     <= 1'b1;
      memw_n     <= 1'b1;
      ior_n      <= 1'b1;
      iow_n      <= 1'b1;
      count_step <= 1'b0;
      eop_out_n  <= 1'b1;
      tc_status  <= '0;
      tc_seen    <= 1'b0;
      eop_seen   <= 1'b0;
    end else begin
      state <= state_nxt;

      // Outputs decoded from the state being entered.
      hrq        <= (state_nxt != ST_SI);
      aen        <= state_nxt inside {ST_S1, ST_S2, ST_S3, ST_S4};
      adstb      <= (state_nxt == ST_S1);
      validDACK  <= state_nxt inside {ST_S2, ST_S3, ST_S4};
      // The read-side strobe opens in S2 and is held through S3; the
      // write-side strobe is S3 only.
      memr_n     <= !(is_read  && (state_nxt inside {ST_S2, ST_S3}));
      ior_n      <= !(is_write && (state_nxt inside {ST_S2, ST_S3}));
      iow_n      <= !(is_read  && (state_nxt == ST_S3));
      memw_n     <= !(is_write && (state_nxt == ST_S3));
      count_step <= (state_nxt == ST_S4);
      eop_out_n  <= !tc_set;

      // Channel is captured once per service and frozen until SI.
      if ((state == ST_S0) && (state_nxt == ST_S1)) active_ch <= encode(grant);

      if (state == ST_S3) begin
        tc_seen  <= tc_in;
        eop_seen <= !eop_in_n;
      end

      // A same-cycle set overrides the clear.
      tc_status <= (tc_clr ? '0 : tc_status) | tc_set_mask;
    end
  end

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dma_timing_ctrl
//
// Directed bench for dma_timing_ctrl. Each table record holds one cycle of
// inputs and the output word expected after the following rising edge.
// Expected words are built from hand-chosen per-phase values. Async reset,
// hlda loss and the tc_clr / tc set collision are hand-written sequences.
//
// Observed word layout (16 bits):
//   {hrq, validDACK, active_ch[1:0], aen, adstb,
//    memr_n, memw_n, ior_n, iow_n, count_step, eop_out_n, tc_status[3:0]}
// ---------------------------------------------------------------------------
module tb_dma_timing_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] valid_dreq;
  logic [3:0] grant;
  logic       hlda;
  logic       cmd_disable;
  logic [7:0] mode_xfer;
  logic [7:0] mode_svc;
  logic       tc_in;
  logic       eop_in_n;
  logic       upper_addr_chg;
  logic       tc_clr;
  logic       hrq;
  logic       validDACK;
  logic [1:0] active_ch;
  logic       aen;
  logic       adstb;
  logic       memr_n;
  logic       memw_n;
  logic       ior_n;
  logic       iow_n;
  logic       count_step;
  logic       eop_out_n;
  logic [3:0] tc_status;

  dma_timing_ctrl #(.NUM_CH(4), .CH_W(2)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .valid_dreq    (valid_dreq),
    .grant         (grant),
    .hlda          (hlda),
    .cmd_disable   (cmd_disable),
    .mode_xfer     (mode_xfer),
    .mode_svc      (mode_svc),
    .tc_in         (tc_in),
    .eop_in_n      (eop_in_n),
    .upper_addr_chg(upper_addr_chg),
    .tc_clr        (tc_clr),
    .hrq           (hrq),
    .validDACK     (validDACK),
    .active_ch     (active_ch),
    .aen           (aen),
    .adstb         (adstb),
    .memr_n        (memr_n),
    .memw_n        (memw_n),
    .ior_n         (ior_n),
    .iow_n         (iow_n),
    .count_step    (count_step),
    .eop_out_n     (eop_out_n),
    .tc_status     (tc_status)
  );

  always #5 CLK = ~CLK;

  logic [15:0] obs;
  assign obs = {hrq, validDACK, active_ch, aen, adstb,
                memr_n, memw_n, ior_n, iow_n, count_step, eop_out_n, tc_status};

  typedef struct {
    int          tid;
    logic [3:0]  vd;
    logic [3:0]  gr;
    logic        hlda;
    logic        dis;
    logic        tc;
    logic        eop_n;
    logic        up;
    logic [7:0]  xfer;
    logic [7:0]  svc;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   cur_tid;
  logic [7:0] cur_xfer;
  logic [7:0] cur_svc;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected-word builders, one per bus phase. cmd = {memr_n,memw_n,ior_n,iow_n}.
  function automatic logic [15:0] pk(bit h, bit d, bit [1:0] c, bit a, bit s,
                                     bit [3:0] cmd, bit st, bit e, bit [3:0] t);
    return {h, d, c, a, s, cmd, st, e, t};
  endfunction
  function automatic logic [15:0] e_idle(bit [1:0] c, bit [3:0] t);
    return pk(0, 0, c, 0, 0, 4'b1111, 0, 1, t);
  endfunction
  function automatic logic [15:0] e_s0(bit [1:0] c, bit [3:0] t);
    return pk(1, 0, c, 0, 0, 4'b1111, 0, 1, t);
  endfunction
  function automatic logic [15:0] e_s1(bit [1:0] c, bit [3:0] t);
    return pk(1, 0, c, 1, 1, 4'b1111, 0, 1, t);
  endfunction
  function automatic logic [15:0] e_cmd(bit [1:0] c, bit [3:0] cmd, bit [3:0] t);
    return pk(1, 1, c, 1, 0, cmd, 0, 1, t);
  endfunction
  function automatic logic [15:0] e_s4(bit [1:0] c, bit e, bit [3:0] t);
    return pk(1, 1, c, 1, 0, 4'b1111, 1, e, t);
  endfunction

  task automatic add(input logic [3:0] vd, input logic [3:0] gr, input logic h,
                     input logic dis, input logic tc, input logic eop_n,
                     input logic up, input logic [15:0] exp);
    vec_t v;
    v.tid = cur_tid; v.vd = vd; v.gr = gr; v.hlda = h; v.dis = dis;
    v.tc = tc; v.eop_n = eop_n; v.up = up;
    v.xfer = cur_xfer; v.svc = cur_svc; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- table ----------------
    // T1: ch2 single/read, hlda two cycles after hrq.
    cur_tid = 1; cur_xfer = 8'h20; cur_svc = 8'h10;
    add(4'b0100, 4'b0100, 0, 0, 0, 1, 0, e_s0(0, 4'b0000));
    add(4'b0100, 4'b0100, 0, 0, 0, 1, 0, e_s0(0, 4'b0000));
    add(4'b0100, 4'b0100, 1, 0, 0, 1, 0, e_s1(2, 4'b0000));
    add(4'b0100, 4'b0100, 1, 0, 0, 1, 0, e_cmd(2, 4'b0111, 4'b0000));
    add(4'b0100, 4'b0100, 1, 0, 0, 1, 0, e_cmd(2, 4'b0110, 4'b0000));
    add(4'b0100, 4'b0100, 1, 0, 0, 1, 0, e_s4(2, 1, 4'b0000));
    add(4'b0100, 4'b0100, 1, 0, 0, 1, 0, e_idle(2, 4'b0000));
    add(4'b0000, 4'b0000, 0, 0, 0, 1, 0, e_idle(2, 4'b0000));
    // T2: ch0 block/write, no upper change, tc on the third transfer.
    cur_tid = 2; cur_xfer = 8'h01; cur_svc = 8'h02;
    add(4'b0001, 4'b0001, 0, 0, 0, 1, 0, e_s0(2, 4'b0000));
    add(4'b0001, 4'b0001, 1, 0, 0, 1, 0, e_s1(0, 4'b0000));
    add(4'b0001, 4'b0001, 1, 0, 0, 1, 0, e_cmd(0, 4'b1101, 4'b0000));
    add(4'b0001, 4'b0001, 1, 0, 0, 1, 0, e_cmd(0, 4'b1001, 4'b0000));
    add(4'b0001, 4'b0001, 1, 0, 0, 1, 0, e_s4(0, 1, 4'b0000));
    add(4'b0001, 4'b0001, 1, 0, 0, 1, 0, e_cmd(0, 4'b1101, 4'b0000));
    add(4'b0001, 4'b0001, 1, 0, 0, 1, 0, e_cmd(0, 4'b1001, 4'b0000));
    add(4'b0001, 4'b0001, 1, 0, 0, 1, 0, e_s4(0, 1, 4'b0000));
    add(4'b0001, 4'b0001, 1, 0, 0, 1, 0, e_cmd(0, 4'b1101, 4'b0000));
    add(4'b0001, 4'b0001, 1, 0, 0, 1, 0, e_cmd(0, 4'b1001, 4'b0000));
    add(4'b0001, 4'b0001, 1, 0, 1, 1, 0, e_s4(0, 0, 4'b0001));
    add(4'b0001, 4'b0001, 1, 0, 0, 1, 0, e_idle(0, 4'b0001));
    add(4'b0000, 4'b0000, 0, 0, 0, 1, 0, e_idle(0, 4'b0001));
    // T3: ch1 demand/verify, request drops after two transfers.
    cur_tid = 3; cur_xfer = 8'h00; cur_svc = 8'h00;
    add(4'b0010, 4'b0010, 0, 0, 0, 1, 0, e_s0(0, 4'b0001));
    add(4'b0010, 4'b0010, 1, 0, 0, 1, 0, e_s1(1, 4'b0001));
    add(4'b0010, 4'b0010, 1, 0, 0, 1, 0, e_cmd(1, 4'b1111, 4'b0001));
    add(4'b0010, 4'b0010, 1, 0, 0, 1, 0, e_cmd(1, 4'b1111, 4'b0001));
    add(4'b0010, 4'b0010, 1, 0, 0, 1, 0, e_s4(1, 1, 4'b0001));
    add(4'b0010, 4'b0010, 1, 0, 0, 1, 0, e_cmd(1, 4'b1111, 4'b0001));
    add(4'b0010, 4'b0010, 1, 0, 0, 1, 0, e_cmd(1, 4'b1111, 4'b0001));
    add(4'b0010, 4'b0010, 1, 0, 0, 1, 0, e_s4(1, 1, 4'b0001));
    add(4'b0000, 4'b0000, 1, 0, 0, 1, 0, e_idle(1, 4'b0001));
    add(4'b0000, 4'b0000, 0, 0, 0, 1, 0, e_idle(1, 4'b0001));
    // T4: ch3 block/read, upper change before the 2nd transfer, EOP in its S3.
    cur_tid = 4; cur_xfer = 8'h80; cur_svc = 8'h80;
    add(4'b1000, 4'b1000, 0, 0, 0, 1, 0, e_s0(1, 4'b0001));
    add(4'b1000, 4'b1000, 1, 0, 0, 1, 0, e_s1(3, 4'b0001));
    add(4'b1000, 4'b1000, 1, 0, 0, 1, 0, e_cmd(3, 4'b0111, 4'b0001));
    add(4'b1000, 4'b1000, 1, 0, 0, 1, 0, e_cmd(3, 4'b0110, 4'b0001));
    add(4'b1000, 4'b1000, 1, 0, 0, 1, 0, e_s4(3, 1, 4'b0001));
    add(4'b1000, 4'b1000, 1, 0, 0, 1, 1, e_s1(3, 4'b0001));
    add(4'b1000, 4'b1000, 1, 0, 0, 1, 0, e_cmd(3, 4'b0111, 4'b0001));
    add(4'b1000, 4'b1000, 1, 0, 0, 1, 0, e_cmd(3, 4'b0110, 4'b0001));
    add(4'b1000, 4'b1000, 1, 0, 0, 0, 0, e_s4(3, 1, 4'b0001));
    add(4'b1000, 4'b1000, 1, 0, 0, 1, 0, e_idle(3, 4'b0001));
    add(4'b0000, 4'b0000, 0, 0, 0, 1, 0, e_idle(3, 4'b0001));
    // T6a: disabled controller ignores all requests.
    cur_tid = 6;
    add(4'b1111, 4'b0001, 0, 1, 0, 1, 0, e_idle(3, 4'b0001));
    add(4'b1111, 4'b0001, 0, 1, 0, 1, 0, e_idle(3, 4'b0001));
    // T7: ch2 block/write, disable raised mid-service: finish S4, then SI.
    cur_tid = 7; cur_xfer = 8'h10; cur_svc = 8'h20;
    add(4'b0100, 4'b0100, 0, 0, 0, 1, 0, e_s0(3, 4'b0001));
    add(4'b0100, 4'b0100, 1, 0, 0, 1, 0, e_s1(2, 4'b0001));
    add(4'b0100, 4'b0100, 1, 1, 0, 1, 0, e_cmd(2, 4'b1101, 4'b0001));
    add(4'b0100, 4'b0100, 1, 1, 0, 1, 0, e_cmd(2, 4'b1001, 4'b0001));
    add(4'b0100, 4'b0100, 1, 1, 0, 1, 0, e_s4(2, 1, 4'b0001));
    add(4'b0100, 4'b0100, 1, 1, 0, 1, 0, e_idle(2, 4'b0001));
    add(4'b0000, 4'b0000, 0, 1, 0, 1, 0, e_idle(2, 4'b0001));

    // ---------------- reset ----------------
    RESET = 1'b0;
    valid_dreq = '0; grant = '0; hlda = 0; cmd_disable = 0;
    mode_xfer = '0; mode_svc = '0; tc_in = 0; eop_in_n = 1;
    upper_addr_chg = 0; tc_clr = 0;
    #12;
    check("reset_state", obs, e_idle(0, 4'b0000));
    @(negedge CLK);
    RESET = 1'b1;

    // ---------------- table replay ----------------
    foreach (vecs[i]) begin
      valid_dreq     = vecs[i].vd;
      grant          = vecs[i].gr;
      hlda           = vecs[i].hlda;
      cmd_disable    = vecs[i].dis;
      tc_in          = vecs[i].tc;
      eop_in_n       = vecs[i].eop_n;
      upper_addr_chg = vecs[i].up;
      mode_xfer      = vecs[i].xfer;
      mode_svc       = vecs[i].svc;
      tick();
      check($sformatf("t%0d.v%0d", vecs[i].tid, i), obs, vecs[i].exp);
    end

    // ---------------- T5: hlda lost in S2, then async reset in S3 ----------------
    cmd_disable = 0; tc_in = 0; eop_in_n = 1; upper_addr_chg = 0;
    mode_xfer = 8'h08; mode_svc = 8'h04;          // ch1 read, single
    valid_dreq = 4'b0010; grant = 4'b0010; hlda = 0;
    tick();
    hlda = 1;
    tick();
    tick();
    check("t5.s2_memr", obs, e_cmd(1, 4'b0111, 4'b0001));
    hlda = 0;
    tick();
    check("t5.hlda_drop_si", obs, e_idle(1, 4'b0001));
    valid_dreq = '0; grant = '0;
    tick();
    check("t5.no_step_after_drop", obs, e_idle(1, 4'b0001));
    valid_dreq = 4'b0010; grant = 4'b0010;
    tick();
    hlda = 1;
    tick();
    tick();
    tick();
    check("t5.s3_before_reset", obs, e_cmd(1, 4'b0110, 4'b0001));
    #2 RESET = 1'b0;
    #1;
    check("t5.async_reset", obs, e_idle(0, 4'b0000));
    valid_dreq = '0; grant = '0; hlda = 0;
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    check("t5.after_reset", obs, e_idle(0, 4'b0000));

    // ---------------- T6b: tc set wins over tc_clr ----------------
    mode_xfer = 8'h00; mode_svc = 8'h55;          // all verify, single
    valid_dreq = 4'b1000; grant = 4'b1000;
    tick();
    hlda = 1;
    tick(); tick(); tick();
    tc_in = 1;
    tick();
    check("t6.ch3_tc_s4", obs, e_s4(3, 0, 4'b1000));
    tc_in = 0; valid_dreq = '0; grant = '0;
    tick();
    check("t6.ch3_done", obs, e_idle(3, 4'b1000));
    hlda = 0;
    tick();
    valid_dreq = 4'b0001; grant = 4'b0001;
    tick();
    hlda = 1;
    tick(); tick(); tick();
    tc_in = 1; tc_clr = 1;
    tick();
    check("t6.set_beats_clr", obs, e_s4(0, 0, 4'b0001));
    tc_in = 0; valid_dreq = '0; grant = '0;
    tick();
    check("t6.clr_released", obs, e_idle(0, 4'b0000));
    tc_clr = 0; hlda = 0;
    tick();
    check("t6.idle_end", obs, e_idle(0, 4'b0000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
